// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and hands
// {instruction, pc} to decode over valid/ready. Define FETCH_PERF_EN to add perf counters.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        dec_ready,
    output logic        dec_valid,
    output logic [31:0] dec_instruction,
    output logic [31:0] dec_pc,
    output logic        fetch_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_HALTED
    } state_e;

    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_misaligned
        $error("instruction_fetch: RESET_PC %h is not 4-byte aligned", RESET_PC);
    end

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        dec_valid_q, dec_valid_d;
    logic [31:0] dec_instr_q, dec_instr_d;
    logic [31:0] dec_pc_q, dec_pc_d;
    logic        fetch_err_q, fetch_err_d;

    logic        handshake;
    logic        redirect_misaligned;

    assign handshake           = (state_q == S_VALID) && dec_valid_q && dec_ready;
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    // Priority: halt handshake, then redirect, then the normal fetch flow.
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_d     = flush_q;
        dec_valid_d = dec_valid_q;
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;
        fetch_err_d = fetch_err_q;

        if (state_q == S_HALTED) begin
            state_d = S_HALTED;
        end else if (handshake && halt) begin
            dec_valid_d = 1'b0;
            state_d     = S_HALTED;
        end else if (redirect_valid) begin
            if (redirect_misaligned) begin
                fetch_err_d = 1'b1;
                dec_valid_d = 1'b0;
                flush_d     = 1'b0;
                state_d     = S_HALTED;
            end else begin
                pc_d = redirect_pc;
                unique case (state_q)
                    S_REQ: begin
                        // A granted request is now in flight for the stale PC; drop its response.
                        if (imem_gnt) begin
                            flush_d = 1'b1;
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            flush_d = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            flush_d = 1'b1;
                            state_d = S_WAIT;
                        end
                    end
                    default: begin
                        dec_valid_d = 1'b0;
                        state_d     = S_REQ;
                    end
                endcase
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_REQ;
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (flush_q) begin
                            flush_d = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            dec_instr_d = imem_rdata;
                            dec_pc_d    = pc_q;
                            dec_valid_d = 1'b1;
                            pc_d        = pc_q + 32'd4;
                            state_d     = S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (dec_ready) begin
                        dec_valid_d = 1'b0;
                        state_d     = S_REQ;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_instr_q <= NOP_INSTR;
            dec_pc_q    <= 32'h0000_0000;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            dec_valid_q <= dec_valid_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_req        = (state_q == S_REQ);
    assign imem_addr       = pc_q;
    assign dec_valid       = dec_valid_q;
    assign dec_instruction = dec_instr_q;
    assign dec_pc          = dec_pc_q;
    assign fetch_err       = fetch_err_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Both counters only move in VALID, so they freeze on their own once HALTED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= 32'h0;
            perf_stall_q   <= 32'h0;
        end else begin
            if (handshake) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if ((state_q == S_VALID) && !dec_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a memory model feeds responses and a
// scoreboard queue holds the {instruction, pc} each decode handshake must present.
module tb_instruction_fetch;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } dec_item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid, halt, dec_ready;
    logic [31:0] redirect_pc;
    logic        dec_valid, fetch_err;
    logic [31:0] dec_instruction, dec_pc;

    logic        imem_req_w, imem_gnt_w, imem_rvalid_w;
    logic [31:0] imem_addr_w, imem_rdata_w;
    logic        redirect_valid_w, halt_w, dec_ready_w;
    logic [31:0] redirect_pc_w;
    logic        dec_valid_w, fetch_err_w;
    logic [31:0] dec_instruction_w, dec_pc_w;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_fetched_w, perf_stall_w;
`endif

    int          checks = 0;
    int          errors = 0;
    dec_item_t   sb[$];
    int          drop_cnt, hs_since_rst;
    bit          gnt_en;
    int          mem_lat;
    bit          pend_valid;
    logic [31:0] pend_addr;
    int          pend_wait;
    bit          w_pend;
    logic [31:0] w_addr;
    logic [31:0] w_addrs[$];

    instruction_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .dec_ready       (dec_ready),
        .dec_valid       (dec_valid),
        .dec_instruction (dec_instruction),
        .dec_pc          (dec_pc),
        .fetch_err       (fetch_err)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_stall      (perf_stall)
`endif
    );

    instruction_fetch #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) dut_w (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req_w),
        .imem_addr       (imem_addr_w),
        .imem_gnt        (imem_gnt_w),
        .imem_rvalid     (imem_rvalid_w),
        .imem_rdata      (imem_rdata_w),
        .redirect_valid  (redirect_valid_w),
        .redirect_pc     (redirect_pc_w),
        .halt            (halt_w),
        .dec_ready       (dec_ready_w),
        .dec_valid       (dec_valid_w),
        .dec_instruction (dec_instruction_w),
        .dec_pc          (dec_pc_w),
        .fetch_err       (fetch_err_w)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched_w),
        .perf_stall      (perf_stall_w)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0BAD_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: score the handshake about to be taken, then at the negedge drive memory responses.
    task automatic tick();
        dec_item_t item;
        if (rst && dec_valid && dec_ready) begin
            hs_since_rst++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed handshake at pc %h expected none", dec_pc);
            end
            if (sb.size() != 0) begin
                item = sb.pop_front();
                check("hs_instr", dec_instruction, item.instr);
                check("hs_pc", dec_pc, item.pc);
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        halt           = 1'b0;
        imem_rvalid    = 1'b0;
        if (pend_valid) begin
            if (pend_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend_valid  = 1'b0;
                if (drop_cnt > 0) begin
                    drop_cnt--;
                end else begin
                    item.instr = mem_word(pend_addr);
                    item.pc    = pend_addr;
                    sb.push_back(item);
                end
            end else begin
                pend_wait--;
            end
        end
        imem_gnt = gnt_en;
        if (imem_gnt && imem_req) begin
            pend_valid = 1'b1;
            pend_addr  = imem_addr;
            pend_wait  = mem_lat - 1;
        end
        imem_rvalid_w = w_pend;
        imem_rdata_w  = mem_word(w_addr);
        w_pend        = imem_req_w;
        w_addr        = imem_addr_w;
        if (imem_req_w) w_addrs.push_back(imem_addr_w);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, imem_req, 0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_dvalid"}, dec_valid, 0);
        check({tag, "_dinstr"}, dec_instruction, NOP);
        check({tag, "_dpc"}, dec_pc, 32'h0);
        check({tag, "_err"}, fetch_err, 0);
        check({tag, "_addr_w"}, imem_addr_w, WRAP_PC);
`ifdef FETCH_PERF_EN
        check({tag, "_perf_f"}, perf_fetched, 32'h0);
        check({tag, "_perf_s"}, perf_stall, 32'h0);
`endif
    endtask

    task automatic do_reset(input string tag);
        rst          = 1'b0;
        hs_since_rst = 0;
        #1;
        check_reset(tag);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0; dec_ready = 1'b0;
        imem_gnt_w = 1'b1; imem_rvalid_w = 1'b0; imem_rdata_w = 32'h0;
        redirect_valid_w = 1'b0; redirect_pc_w = 32'h0; halt_w = 1'b0; dec_ready_w = 1'b1;
        gnt_en = 1'b1; mem_lat = 1; pend_valid = 1'b0; pend_addr = 32'h0; pend_wait = 0;
        drop_cnt = 0; hs_since_rst = 0; w_pend = 1'b0; w_addr = 32'h0;
        #2 rst = 1'b0;
        #1;
        check_reset("rst0");
        tick();
        rst = 1'b1;
        dec_ready = 1'b1;

        // Straight-line fetch: one word every 3 cycles, first dec_valid 3 cycles after release.
        tick(); check("t1_req0", imem_req, 1); check("t1_addr0", imem_addr, 32'h0);
        tick(); check("t1_wait_noreq", imem_req, 0);
        tick(); check("t1_valid0", dec_valid, 1); check("t1_pc0", dec_pc, 32'h0);
        check("t1_w_pc0", dec_pc_w, WRAP_PC); check("t1_w_instr0", dec_instruction_w, mem_word(WRAP_PC));
        tick(); check("t1_addr4", imem_addr, 32'd4); check("t1_valid_drop", dec_valid, 0);
        tick();
        tick(); check("t1_valid4", dec_valid, 1); check("t1_pc4", dec_pc, 32'd4);
        check("t1_w_pc_wrap", dec_pc_w, 32'h0);
        tick(); check("t1_addr8", imem_addr, 32'd8);
        tick();
        tick(); check("t1_valid8", dec_valid, 1); check("t1_pc8", dec_pc, 32'd8);
        check("t6_w_nreq", 32'(w_addrs.size()), 32'd3);
        check("t6_w_addr0", w_addrs[0], WRAP_PC);
        check("t6_w_addr1", w_addrs[1], 32'h0);

        // Decode back-pressure: outputs hold, no request.
        dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_valid", dec_valid, 1);
            check("t2_pc", dec_pc, 32'd8);
            check("t2_instr", dec_instruction, mem_word(32'd8));
            check("t2_noreq", imem_req, 0);
        end
`ifdef FETCH_PERF_EN
        check("t2_perf_stall", perf_stall, 32'd5);
        check("t2_perf_fetched", perf_fetched, 32'(hs_since_rst));
`endif
        dec_ready = 1'b1;
        mem_lat   = 3;

        // Redirect while waiting: in-flight response dropped, refetch from target.
        tick(); check("t3_req12", imem_req, 1); check("t3_addr12", imem_addr, 32'd12);
        tick(); check("t3_in_wait", imem_req, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h100; drop_cnt++;
        tick(); check("t3_drop_a", dec_valid, 0); check("t3_noreq", imem_req, 0);
        tick(); check("t3_drop_b", dec_valid, 0);
        mem_lat = 1;
        tick(); check("t3_req_tgt", imem_req, 1); check("t3_addr_tgt", imem_addr, 32'h100);
        check("t3_drop_c", dec_valid, 0);
        tick();
        tick(); check("t3_valid_tgt", dec_valid, 1); check("t3_pc_tgt", dec_pc, 32'h100);
        gnt_en = 1'b0;

        // Redirect on an ungranted request: address switches, still requesting.
        tick(); check("t3b_addr", imem_addr, 32'h104); check("t3b_req", imem_req, 1);
        redirect_valid = 1'b1; redirect_pc = 32'h40; gnt_en = 1'b1;
        tick(); check("t3b_req_tgt", imem_req, 1); check("t3b_addr_tgt", imem_addr, 32'h40);
        tick();
        tick(); check("t3b_valid", dec_valid, 1); check("t3b_pc", dec_pc, 32'h40);

        // Misaligned redirect on a granted request: sticky error, halted.
        tick(); check("t5_addr", imem_addr, 32'h44);
        redirect_valid = 1'b1; redirect_pc = 32'h102; drop_cnt++;
        tick(); check("t5_err", fetch_err, 1); check("t5_noreq", imem_req, 0); check("t5_novalid", dec_valid, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_halt_noreq", imem_req, 0);
            check("t5_err_sticky", fetch_err, 1);
            check("t5_halt_novalid", dec_valid, 0);
        end

        // Halt on handshake: nothing more issued, redirect ignored.
        do_reset("rst1");
        for (int i = 0; i < 10 && !dec_valid; i++) tick();
        check("t4_valid", dec_valid, 1);
        check("t4_pc", dec_pc, 32'h0);
        halt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t4_noreq", imem_req, 0);
            check("t4_novalid", dec_valid, 0);
            if (i == 5) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h200;
            end
        end
        check("t4_pc_frozen", imem_addr, 32'd4);
        check("t4_no_err", fetch_err, 0);
`ifdef FETCH_PERF_EN
        check("t4_perf_fetched", perf_fetched, 32'(hs_since_rst));
        check("t4_perf_stall", perf_stall, 32'd0);
`endif

        // Reset in WAIT: immediate reset values, late response ignored.
        do_reset("rst2");
        mem_lat = 3;
        tick(); check("t6_req", imem_req, 1); check("t6_addr", imem_addr, 32'h0);
        tick(); check("t6_in_wait", imem_req, 0);
        gnt_en = 1'b0;
        drop_cnt++;
        do_reset("rst3");
        tick(); check("t6_late_req", imem_req, 1); check("t6_late_rvalid_seen", imem_rvalid, 1);
        tick(); check("t6_late_ignored", dec_valid, 0); check("t6_still_req", imem_req, 1);
        check("t6_addr_reset", imem_addr, 32'h0);
        gnt_en  = 1'b1;
        mem_lat = 1;
        tick();
        tick();
        tick(); check("t6_valid", dec_valid, 1); check("t6_pc", dec_pc, 32'h0);
        check("t6_instr", dec_instruction, mem_word(32'h0));
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("drops_consumed", 32'(drop_cnt), 32'd0);
        check("w_no_err", fetch_err_w, 0);
        check("w_dvalid_known", 32'(dec_valid_w !== 1'bx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
